// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS-lite pipeline: shadow
// scoreboard, stall/flush, registered forwarding selects, HALT drain FSM, stats.
module hazard_ctrl #(
    parameter int REGADDR    = 5,
    parameter bit FORWARDING = 1'b1,
    parameter int CNTW       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REGADDR-1:0] id_rs,
    input  logic [REGADDR-1:0] id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [REGADDR-1:0] id_dest,
    input  logic               id_writes_reg,
    input  logic               id_is_load,
    input  logic               id_is_halt,
    input  logic               ex_branch_taken,
    output logic               stall,
    output logic               flush,
    output logic               stop_fetch,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               halted,
    output logic [CNTW-1:0]    stall_cycles,
    output logic [CNTW-1:0]    flush_cycles
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_TWO = {{(CNTW-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // WB slot needs no storage: it never stalls or forwards, only HALT's
    // arrival there (the edge leaving MEM) matters.
    logic               ex_vld_q, ex_wr_q, ex_ld_q, ex_ht_q;
    logic [REGADDR-1:0] ex_dst_q;
    logic               ex_vld_d, ex_wr_d, ex_ld_d, ex_ht_d;
    logic [REGADDR-1:0] ex_dst_d;
    logic               mem_vld_q, mem_wr_q, mem_ht_q;
    logic [REGADDR-1:0] mem_dst_q;

    logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic            stop_fetch_q, halted_q;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic id_live_s, ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s;
    logic stall_s, flush_s, accept_s;

    function automatic logic src_match(input logic vld, input logic wr,
                                       input logic [REGADDR-1:0] dst,
                                       input logic [REGADDR-1:0] src,
                                       input logic uses);
        return vld & wr & uses & (dst == src) & (src != {REGADDR{1'b0}});
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        logic [1:0] sel;
        if (ex_hit) begin
            sel = 2'b01;
        end else if (mem_hit) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection: same-cycle stall/flush and ID acceptance
    always_comb begin
        ex_rs_s   = src_match(ex_vld_q, ex_wr_q, ex_dst_q, id_rs, id_uses_rs);
        ex_rt_s   = src_match(ex_vld_q, ex_wr_q, ex_dst_q, id_rt, id_uses_rt);
        mem_rs_s  = src_match(mem_vld_q, mem_wr_q, mem_dst_q, id_rs, id_uses_rs);
        mem_rt_s  = src_match(mem_vld_q, mem_wr_q, mem_dst_q, id_rt, id_uses_rt);
        id_live_s = id_valid && (state_q == ST_RUN);
        flush_s   = 1'b0;
        stall_s   = 1'b0;
        if (reset && (state_q != ST_DONE)) begin
            flush_s = ex_branch_taken;
        end else begin
            flush_s = 1'b0;
        end
        if (reset && id_live_s && !flush_s) begin
            if (FORWARDING) begin
                stall_s = ex_ld_q && (ex_rs_s || ex_rt_s);
            end else begin
                stall_s = ex_rs_s || ex_rt_s || mem_rs_s || mem_rt_s;
            end
        end else begin
            stall_s = 1'b0;
        end
        accept_s = id_live_s && !stall_s && !flush_s;
    end

    // Next state: scoreboard shift, forwarding selects, HALT FSM, counters
    always_comb begin
        state_d     = state_q;
        ex_vld_d    = 1'b0;
        ex_dst_d    = {REGADDR{1'b0}};
        ex_wr_d     = 1'b0;
        ex_ld_d     = 1'b0;
        ex_ht_d     = 1'b0;
        fwd_a_d     = 2'b00;
        fwd_b_d     = 2'b00;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (accept_s) begin
            ex_vld_d = 1'b1;
            ex_dst_d = id_dest;
            ex_wr_d  = id_writes_reg;
            ex_ld_d  = id_is_load;
            ex_ht_d  = id_is_halt;
            if (FORWARDING) begin
                fwd_a_d = fwd_sel(ex_rs_s, mem_rs_s);
                fwd_b_d = fwd_sel(ex_rt_s, mem_rt_s);
            end else begin
                fwd_a_d = 2'b00;
                fwd_b_d = 2'b00;
            end
        end else begin
            ex_vld_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (accept_s && id_is_halt) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (mem_vld_q && mem_ht_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase

        if (state_q != ST_DONE) begin
            if (stall_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_s) begin
                flush_cnt_d = (flush_cnt_q >= (CNT_MAX - CNT_ONE)) ? CNT_MAX
                                                                   : flush_cnt_q + CNT_TWO;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            ex_vld_q     <= 1'b0;
            ex_dst_q     <= {REGADDR{1'b0}};
            ex_wr_q      <= 1'b0;
            ex_ld_q      <= 1'b0;
            ex_ht_q      <= 1'b0;
            mem_vld_q    <= 1'b0;
            mem_dst_q    <= {REGADDR{1'b0}};
            mem_wr_q     <= 1'b0;
            mem_ht_q     <= 1'b0;
            fwd_a_q      <= 2'b00;
            fwd_b_q      <= 2'b00;
            stop_fetch_q <= 1'b0;
            halted_q     <= 1'b0;
            stall_cnt_q  <= {CNTW{1'b0}};
            flush_cnt_q  <= {CNTW{1'b0}};
        end else begin
            state_q      <= state_d;
            ex_vld_q     <= ex_vld_d;
            ex_dst_q     <= ex_dst_d;
            ex_wr_q      <= ex_wr_d;
            ex_ld_q      <= ex_ld_d;
            ex_ht_q      <= ex_ht_d;
            mem_vld_q    <= ex_vld_q;
            mem_dst_q    <= ex_dst_q;
            mem_wr_q     <= ex_wr_q;
            mem_ht_q     <= ex_ht_q;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            stop_fetch_q <= (state_d != ST_RUN);
            halted_q     <= (state_d == ST_DONE);
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall        = stall_s;
    assign flush        = flush_s;
    assign stop_fetch   = stop_fetch_q;
    assign halted       = halted_q;
    assign fwd_a        = fwd_a_q;
    assign fwd_b        = fwd_b_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one forwarding instance and one stall-only instance
// (narrow counters) share stimulus and are checked against a cycle-indexed model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, id_uses_rs, id_uses_rt, id_writes_reg;
    logic       id_is_load, id_is_halt, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_dest;

    logic        stall0, flush0, stopf0, halted0;
    logic [1:0]  fa0, fb0;
    logic [31:0] sc0, fc0;
    logic        stall1, flush1, stopf1, halted1;
    logic [1:0]  fa1, fb1;
    logic [4:0]  sc1, fc1;

    hazard_ctrl #(.REGADDR(5), .FORWARDING(1'b1), .CNTW(32)) u_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_writes_reg(id_writes_reg), .id_is_load(id_is_load),
        .id_is_halt(id_is_halt), .ex_branch_taken(ex_branch_taken),
        .stall(stall0), .flush(flush0), .stop_fetch(stopf0), .fwd_a(fa0), .fwd_b(fb0),
        .halted(halted0), .stall_cycles(sc0), .flush_cycles(fc0));

    hazard_ctrl #(.REGADDR(5), .FORWARDING(1'b0), .CNTW(5)) u_stl (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_writes_reg(id_writes_reg), .id_is_load(id_is_load),
        .id_is_halt(id_is_halt), .ex_branch_taken(ex_branch_taken),
        .stall(stall1), .flush(flush1), .stop_fetch(stopf1), .fwd_a(fa1), .fwd_b(fb1),
        .halted(halted1), .stall_cycles(sc1), .flush_cycles(fc1));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam int N = 2048;
    // Model: what each instance accepted from ID in each cycle. An instruction
    // accepted in cycle t sits in EX during t+1 and in MEM during t+2.
    bit         acc_v [2][N];
    bit         acc_w [2][N];
    bit         acc_l [2][N];
    logic [4:0] acc_d [2][N];
    int         win    [2];
    int         halt_c [2];
    logic [1:0] efa [2];
    logic [1:0] efb [2];
    longint     esc [2];
    longint     efc [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint cmax(input int m);
        return (m == 0) ? 64'hFFFF_FFFF : 64'd31;
    endfunction

    function automatic bit hit(input int m, input int cy, input logic [4:0] src, input bit uses);
        if (cy < 0 || cy < win[m]) return 1'b0;
        return acc_v[m][cy] && acc_w[m][cy] && uses && (src != 5'd0) && (acc_d[m][cy] == src);
    endfunction

    function automatic logic [1:0] sel(input bit e, input bit mm);
        return e ? 2'b01 : (mm ? 2'b10 : 2'b00);
    endfunction

    task automatic model_cycle(input int m);
        bit running, done, fl, st, hz, acc, ex_ld, rs_ex, rt_ex, rs_mem, rt_mem;
        running = (halt_c[m] < 0);
        done    = !running && (cyc >= halt_c[m] + 3);
        rs_ex   = hit(m, cyc - 1, id_rs, id_uses_rs);
        rt_ex   = hit(m, cyc - 1, id_rt, id_uses_rt);
        rs_mem  = hit(m, cyc - 2, id_rs, id_uses_rs);
        rt_mem  = hit(m, cyc - 2, id_rt, id_uses_rt);
        ex_ld   = 1'b0;
        if (cyc >= 1 && cyc - 1 >= win[m]) ex_ld = acc_v[m][cyc-1] && acc_l[m][cyc-1];
        fl = reset && ex_branch_taken && !done;
        hz = (m == 0) ? (ex_ld && (rs_ex || rt_ex)) : (rs_ex || rt_ex || rs_mem || rt_mem);
        st = reset && id_valid && running && !fl && hz;

        check($sformatf("stall%0d c%0d", m, cyc), (m == 0) ? stall0 : stall1, st);
        check($sformatf("flush%0d c%0d", m, cyc), (m == 0) ? flush0 : flush1, fl);
        check($sformatf("fwd_a%0d c%0d", m, cyc), (m == 0) ? fa0 : fa1, efa[m]);
        check($sformatf("fwd_b%0d c%0d", m, cyc), (m == 0) ? fb0 : fb1, efb[m]);
        check($sformatf("stop_fetch%0d c%0d", m, cyc), (m == 0) ? stopf0 : stopf1, !running);
        check($sformatf("halted%0d c%0d", m, cyc), (m == 0) ? halted0 : halted1, done);
        check($sformatf("stall_cycles%0d c%0d", m, cyc), (m == 0) ? sc0 : {27'd0, sc1}, esc[m]);
        check($sformatf("flush_cycles%0d c%0d", m, cyc), (m == 0) ? fc0 : {27'd0, fc1}, efc[m]);

        if (!reset) begin
            win[m]         = cyc + 1;
            halt_c[m]      = -1;
            efa[m]         = 2'b00;
            efb[m]         = 2'b00;
            esc[m]         = 0;
            efc[m]         = 0;
            acc_v[m][cyc]  = 1'b0;
        end else begin
            acc = id_valid && running && !st && !fl;
            acc_v[m][cyc] = acc;
            acc_w[m][cyc] = id_writes_reg;
            acc_l[m][cyc] = id_is_load;
            acc_d[m][cyc] = id_dest;
            if (acc && id_is_halt) halt_c[m] = cyc;
            efa[m] = (acc && m == 0) ? sel(rs_ex, rs_mem) : 2'b00;
            efb[m] = (acc && m == 0) ? sel(rt_ex, rt_mem) : 2'b00;
            if (!done) begin
                if (st) esc[m] = (esc[m] + 1 > cmax(m)) ? cmax(m) : esc[m] + 1;
                if (fl) efc[m] = (efc[m] + 2 > cmax(m)) ? cmax(m) : efc[m] + 2;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [4:0] rs, input bit urs,
                         input logic [4:0] rt, input bit urt, input logic [4:0] dst,
                         input bit wr, input bit ld, input bit ht, input bit br);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_dest = dst; id_writes_reg = wr; id_is_load = ld; id_is_halt = ht;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst_pulse();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            win[m] = 0; halt_c[m] = -1; efa[m] = 2'b00; efb[m] = 2'b00;
            esc[m] = 0; efc[m] = 0;
        end
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step();
        reset = 1'b1;

        // ADD R1 then SUB R2,R1,R3: operand from EX/MEM
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); step();
        check("sub fwd_a from ex", fa0, 2'b01);
        idle(); step(); step(); step();

        // one independent instruction between: operand from MEM/WB
        rst_pulse();
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); step();
        check("sub fwd_a from mem", fa0, 2'b10);
        idle(); step(); step(); step();

        // LDW R4 then ADD R5,R4,R4 held in ID while stalled
        rst_pulse();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); step();
        check("ldu stall_cycles fwd after 1", sc0, 32'd1);
        step();
        check("ldu fwd_a", fa0, 2'b10);
        check("ldu fwd_b", fb0, 2'b10);
        check("ldu stall_cycles fwd", sc0, 32'd1);
        check("ldu stall_cycles nofwd", sc1, 5'd2);
        step();
        check("ldu nofwd fwd_a", fa1, 2'b00);
        check("ldu stall_cycles nofwd final", sc1, 5'd2);
        idle(); step(); step();

        // taken branch in EX while a load-use pair is in ID
        rst_pulse();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); step();
        check("br flush_cycles fwd", fc0, 32'd2);
        check("br stall_cycles fwd", sc0, 32'd0);
        check("br flush_cycles nofwd", fc1, 5'd2);
        check("br stall_cycles nofwd", sc1, 5'd0);
        idle(); step();

        // R0 is never a hazard
        rst_pulse();
        drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); step(); step();
        check("r0 stall_cycles fwd", sc0, 32'd0);
        check("r0 stall_cycles nofwd", sc1, 5'd0);
        check("r0 fwd_a", fa0, 2'b00);
        idle(); step();

        // HALT drain, freeze in DONE, reset clears
        rst_pulse();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        check("halt stop_fetch", stopf0, 1'b1);
        check("halt halted early", halted0, 1'b0);
        idle(); step();
        check("halt halted edge2", halted0, 1'b0);
        step();
        check("halt halted edge3 fwd", halted0, 1'b1);
        check("halt halted edge3 nofwd", halted1, 1'b1);
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); step(); step();
        check("done flush frozen", fc0, 32'd0);
        check("done stall frozen", sc1, 5'd0);
        rst_pulse();
        check("rst halted", halted0, 1'b0);
        check("rst stop_fetch", stopf0, 1'b0);

        // reset while draining
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        rst_pulse();
        check("drain rst stop_fetch", stopf1, 1'b0);

        // randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            bit both_done;
            both_done = (halt_c[0] >= 0) && (cyc >= halt_c[0] + 5) &&
                        (halt_c[1] >= 0) && (cyc >= halt_c[1] + 5);
            reset = !both_done && ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
